// File: rtl/mc_ctrl_unit.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/write-back,
// with ALU-control and immediate-extend decoding, illegal-instruction and completion flags.
module mc_ctrl_unit #(
  parameter int ALUCTL_W   = 3,
  parameter bit EN_IMM_OPS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                pc_en,
  output logic                iord,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                ext_op,
  output logic                illegal,
  output logic                instr_done,
  output logic [3:0]          state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW   = 6'b101011,
                         OP_BEQ   = 6'b000100, OP_J    = 6'b000010, OP_ADDI = 6'b001000,
                         OP_ANDI  = 6'b001100, OP_SLTI = 6'b001010, OP_ORI  = 6'b001101;

  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                         ALU_OR  = 3'b001, ALU_SLT = 3'b111;

  state_t     state, state_nxt;
  logic       pc_write, branch, ir_load, mem_wr, reg_wr, ill_raw, done_raw;
  logic [2:0] alu_code;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000: funct_legal = 1'b1;
      default: funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_AND;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] o);
    case (o)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      OP_SLTI: imm_alu = ALU_SLT;
      default: imm_alu = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = S_FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_load    = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    ill_raw    = 1'b0;
    done_raw   = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_code   = ALU_AND;
    ext_op     = 1'b1;
    case (state)
      S_FETCH: begin
        alu_src_b = 2'b01;
        alu_code  = ALU_ADD;
        ir_load   = 1'b1;
        pc_write  = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_code  = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     if (funct_legal(funct)) state_nxt = S_EXEC; else ill_raw = 1'b1;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI, OP_ANDI, OP_SLTI, OP_ORI:
                        if (EN_IMM_OPS) state_nxt = S_IMMEX; else ill_raw = 1'b1;
          default:      ill_raw = 1'b1;
        endcase
        // An illegal instruction ends here and falls back to FETCH.
        done_raw = ill_raw;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_code  = ALU_ADD;
        state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord      = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
        done_raw   = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        mem_wr   = 1'b1;
        done_raw = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_code  = funct_alu(funct);
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst  = 1'b1;
        reg_wr   = 1'b1;
        done_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_code  = ALU_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        done_raw  = 1'b1;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_code  = imm_alu(op);
        ext_op    = !((op == OP_ANDI) || (op == OP_ORI));
        state_nxt = S_IMMWB;
      end
      S_IMMWB: begin
        reg_wr   = 1'b1;
        done_raw = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        done_raw = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Enables and pulses are gated by rst_n so nothing writes while reset is held.
  assign pc_en      = rst_n & (pc_write | (branch & zero));
  assign ir_write   = rst_n & ir_load;
  assign mem_write  = rst_n & mem_wr;
  assign reg_write  = rst_n & reg_wr;
  assign illegal    = rst_n & ill_raw;
  assign instr_done = rst_n & done_raw;
  assign alu_ctl    = ALUCTL_W'(alu_code);
  assign state_o    = state;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Bench for mc_ctrl_unit: per-cycle expected control words queued per instruction and
// compared each cycle; a second instance covers ALUCTL_W=4 with immediate ops disabled.
module tb_mc_ctrl_unit;

  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;

  logic pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctl;
  logic ext_op, illegal, instr_done;
  logic [3:0] state_o;

  logic b_pc_en, b_iord, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg, b_reg_write, b_alu_src_a;
  logic [1:0] b_alu_src_b, b_pc_src;
  logic [3:0] b_alu_ctl;
  logic b_ext_op, b_illegal, b_instr_done;
  logic [3:0] b_state_o;

  mc_ctrl_unit #(.ALUCTL_W(3), .EN_IMM_OPS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctl(alu_ctl),
    .ext_op(ext_op), .illegal(illegal), .instr_done(instr_done), .state_o(state_o));

  mc_ctrl_unit #(.ALUCTL_W(4), .EN_IMM_OPS(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .pc_en(b_pc_en), .iord(b_iord), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .pc_src(b_pc_src), .alu_ctl(b_alu_ctl),
    .ext_op(b_ext_op), .illegal(b_illegal), .instr_done(b_instr_done), .state_o(b_state_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] st2;
    logic       ill2;
    logic       a2hi;
    logic       ill;
    logic       done;
    logic       pcen;
    logic       irw;
    logic       rw;
    logic       mw;
    logic       iord;
    logic       m2r;
    logic       rdst;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] pcs;
    logic [2:0] alu;
    logic       ext;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic exp_t base(input int s);
    exp_t e = '0;
    e.st = 4'(s); e.st2 = 4'(s); e.ext = 1'b1;
    case (s)
      0:  begin e.asb = 2'b01; e.alu = 3'b010; e.irw = 1'b1; e.pcen = 1'b1; end
      1:  begin e.asb = 2'b11; e.alu = 3'b010; end
      2:  begin e.asa = 1'b1; e.asb = 2'b10; e.alu = 3'b010; end
      3:  e.iord = 1'b1;
      4:  begin e.m2r = 1'b1; e.rw = 1'b1; e.done = 1'b1; end
      5:  begin e.iord = 1'b1; e.mw = 1'b1; e.done = 1'b1; end
      6:  e.asa = 1'b1;
      7:  begin e.rdst = 1'b1; e.rw = 1'b1; e.done = 1'b1; end
      8:  begin e.asa = 1'b1; e.alu = 3'b110; e.pcs = 2'b01; e.done = 1'b1; end
      9:  begin e.asa = 1'b1; e.asb = 2'b10; end
      10: begin e.rw = 1'b1; e.done = 1'b1; end
      11: begin e.pcs = 2'b10; e.pcen = 1'b1; e.done = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.st = state_o; o.st2 = b_state_o; o.ill2 = b_illegal; o.a2hi = b_alu_ctl[3];
    o.ill = illegal; o.done = instr_done; o.pcen = pc_en; o.irw = ir_write;
    o.rw = reg_write; o.mw = mem_write; o.iord = iord; o.m2r = mem_to_reg;
    o.rdst = reg_dst; o.asa = alu_src_a; o.asb = alu_src_b; o.pcs = pc_src;
    o.alu = alu_ctl; o.ext = ext_op;
    return o;
  endfunction

  function automatic exp_t illegal_decode();
    exp_t e = base(1);
    e.ill = 1'b1; e.done = 1'b1; e.ill2 = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    logic [9:0] got;
    rst_n = 1'b0; op = 6'b100011;
    @(negedge clk); @(negedge clk); #1;
    got = {state_o, pc_en, ir_write, mem_write, reg_write, illegal, instr_done};
    n_cmp++;
    if (got !== 10'd0) begin
      n_bad++; $display("FAIL reset_state: got %b required %b", got, 10'd0);
    end
    @(negedge clk);
  endtask

  task automatic test_lw();
    exp_t e, o;
    op = 6'b100011; rst_n = 1'b1;
    for (int s = 0; s <= 4; s++) sb.push_back(base(s));
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL lw st%0d: got %h required %h", e.st, o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    exp_t e, o;
    logic [5:0] fn [3] = '{6'b101010, 6'b100010, 6'b000000};
    logic [2:0] ac [3] = '{3'b111, 3'b110, 3'b000};
    op = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      funct = fn[k];
      sb.push_back(base(0)); sb.push_back(base(1));
      e = base(6); e.alu = ac[k]; sb.push_back(e);
      sb.push_back(base(7));
      while (sb.size() > 0) begin
        #1; e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL rtype f%b st%0d: got %h required %h", funct, e.st, o, e); end
        @(negedge clk);
      end
    end
    funct = 6'b100111;
    sb.push_back(base(0)); sb.push_back(illegal_decode());
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rtype_illegal st%0d: got %h required %h", e.st, o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    exp_t e, o;
    op = 6'b000100; funct = 6'd0;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      sb.push_back(base(0)); sb.push_back(base(1));
      e = base(8); e.pcen = z[0]; sb.push_back(e);
      while (sb.size() > 0) begin
        #1; e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL beq z%0d st%0d: got %h required %h", z, e.st, o, e); end
        @(negedge clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_imm();
    exp_t e, o;
    logic [5:0] ops [4] = '{6'b001101, 6'b001000, 6'b001100, 6'b001010};
    logic [2:0] ac  [4] = '{3'b001, 3'b010, 3'b000, 3'b111};
    logic       ex  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      op = ops[k];
      sb.push_back(base(0));
      e = base(1); e.ill2 = 1'b1; sb.push_back(e);
      e = base(9); e.alu = ac[k]; e.ext = ex[k]; e.st2 = 4'd0; sb.push_back(e);
      e = base(10); e.st2 = 4'd1; e.ill2 = 1'b1; sb.push_back(e);
      while (sb.size() > 0) begin
        #1; e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL imm op%b st%0d: got %h required %h", op, e.st, o, e); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jump_sw();
    exp_t e, o;
    op = 6'b000010;
    sb.push_back(base(0)); sb.push_back(base(1)); sb.push_back(base(11));
    op = 6'b000010;
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL jump st%0d: got %h required %h", e.st, o, e); end
      @(negedge clk);
    end
    op = 6'b101011;
    sb.push_back(base(0)); sb.push_back(base(1)); sb.push_back(base(2)); sb.push_back(base(5));
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sw st%0d: got %h required %h", e.st, o, e); end
      @(negedge clk);
    end
    op = 6'b111111;
    sb.push_back(base(0)); sb.push_back(illegal_decode());
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL bad_op st%0d: got %h required %h", e.st, o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    logic [9:0] got;
    op = 6'b101011;
    for (int s = 0; s < 3; s++) sb.push_back(base(s));
    sb.push_back(base(5));
    while (sb.size() > 1) begin
      #1; e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sw_pre_reset st%0d: got %h required %h", e.st, o, e); end
      @(negedge clk);
    end
    #1; e = sb.pop_front(); o = observe(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL sw_in_memwr: got %h required %h", o, e); end
    #2 rst_n = 1'b0;
    #1;
    got = {state_o, pc_en, ir_write, mem_write, reg_write, illegal, instr_done};
    n_cmp++;
    if (got !== 10'd0) begin
      n_bad++; $display("FAIL reset_mid_memwr: got %b required %b", got, 10'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; op = 6'b000010;
    sb.push_back(base(0)); sb.push_back(base(1)); sb.push_back(base(11));
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL resume_jump st%0d: got %h required %h", e.st, o, e); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_imm();
    test_jump_sw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_unit.md
# mc_ctrl_unit

Multicycle MIPS control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back, and folds in a corrected, parametrised ALU/extend decoder. It sits between the instruction register (`op`, `funct`) and the multicycle datapath (PC, memory mux, register file, ALU muxes). Outputs are decoded from the registered state, plus `op`/`funct` in the execute states. It also flags illegal instructions and marks instruction completion.

## Interface
- `ALUCTL_W`, default 3: width of `alu_ctl`, must be ≥3. Codes sit in bits [2:0]; upper bits are 0.
- `EN_IMM_OPS`, default 1: 1 enables addi/andi/ori/slti; 0 treats their opcodes as illegal.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  6  IR[31:26], stable from the cycle after FETCH.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag, same cycle.
- `pc_en`  out  1  PC load = pc_write | (branch & zero).
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  data memory write.
- `ir_write`  out  1  instruction register load.
- `reg_dst`  out  1  write register: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write data: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  1  0 = PC, 1 = A.
- `alu_src_b`  out  2  00 = B, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_ctl`  out  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `ext_op`  out  1  1 = sign-extend, 0 = zero-extend.
- `illegal`  out  1  one-cycle pulse for an unsupported instruction.
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `state_o`  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11. Encodings 12–15 go to FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by `op`:
    - lw 100011 / sw 101011 → MEMADR.
    - R-type 000000 → EXEC.
    - beq 000100 → BRANCH.
    - addi 001000, andi 001100, slti 001010, ori 001101 → IMMEX (only if EN_IMM_OPS).
    - j 000010 → JUMP.
    - Anything else → FETCH, with `illegal` = 1.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB. EXEC → ALUWB. IMMEX → IMMWB.
  - MEMWB, MEMWR, ALUWB, IMMWB, BRANCH, JUMP → FETCH.
- R-type legality, checked in DECODE:
  - Legal funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 nop (alu_ctl 000).
  - Any other funct → illegal, return to FETCH.
- Per-state outputs. Anything not listed is 0; `ext_op` defaults to 1.
  - FETCH: alu_src_b 01, alu_ctl add, pc_src 00, ir_write 1, pc_write 1.
  - DECODE: alu_src_b 11, alu_ctl add (branch target).
  - MEMADR: alu_src_a 1, alu_src_b 10, alu_ctl add.
  - MEMRD: iord 1.
  - MEMWB: mem_to_reg 1, reg_write 1.
  - MEMWR: iord 1, mem_write 1.
  - EXEC: alu_src_a 1, alu_src_b 00, alu_ctl from funct.
  - ALUWB: reg_dst 1, reg_write 1.
  - BRANCH: alu_src_a 1, alu_ctl sub, pc_src 01, branch 1.
  - IMMEX: alu_src_a 1, alu_src_b 10; alu_ctl from op: addi add, andi and, ori or, slti slt. `ext_op` is 0 for andi/ori and 1 for addi/slti.
  - IMMWB: reg_write 1, reg_dst 0.
  - JUMP: pc_src 10, pc_write 1.
- `instr_done` is high in MEMWB, MEMWR, ALUWB, IMMWB, BRANCH and JUMP, and in DECODE when the instruction is illegal.

## Timing
- Reset:
  - `rst_n` low forces state to FETCH immediately.
  - While `rst_n` is low, all enables (pc_en, ir_write, mem_write, reg_write) and the `illegal`/`instr_done` pulses are forced to 0.
  - The first FETCH is performed on the first rising edge after release.
- Cycles per instruction, FETCH inclusive: lw 5; sw, R-type and I-ALU 4; beq and j 3; illegal 2.
- `pc_en` in BRANCH follows `zero` combinationally in the same cycle.
- `illegal` and `instr_done` are combinational from the state and held-stable IR fields. They are exactly one cycle wide.
- Reset asserted mid-instruction abandons the instruction with no write.

## Test plan
- Reset, then release with op=100011 (lw) → state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done pulses once.
- R-type funct=101010 → alu_ctl=111 in EXEC, reg_dst=1 in ALUWB; funct=100111 → illegal=1 in DECODE, next state 0, no reg_write.
- beq with zero=1 → pc_en=1, pc_src=01 in BRANCH; same with zero=0 → pc_en=0; 3 cycles each.
- ori (001101) → ext_op=0 and alu_ctl=001 in IMMEX; addi → ext_op=1, alu_ctl=010; with EN_IMM_OPS=0, ori → illegal.
- j → pc_src=10, pc_en=1 in state 11; sw → mem_write=1, iord=1 in state 5 only; ALUCTL_W=4 → alu_ctl[3]=0 always.
- rst_n dropped in MEMWR → mem_write falls immediately, state_o=0; after release, normal fetch resumes.
